// File: rtl/audio_fx_pkg.sv
// Shared types and helpers for the audio effect stages: sample width,
// pass-sequencer states and a 17-to-16-bit saturating clamp.
package audio_fx_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SAMPLE_W:0]   sum17_t;

    localparam sample_t SAT_MAX = 16'sh7FFF;
    localparam sample_t SAT_MIN = 16'sh8000;

    localparam sum17_t SUM_MAX = 17'sd32767;
    localparam sum17_t SUM_MIN = -17'sd32768;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        CALC,
        WR
    } state_t;

    function automatic sample_t sat16(input sum17_t s);
        sample_t r;
        if (s > SUM_MAX) begin
            r = SAT_MAX;
        end else if (s < SUM_MIN) begin
            r = SAT_MIN;
        end else begin
            r = s[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_delay_ram.sv
// Simple dual-port sample memory, one write and one read port, no reset.
// Latency: read data registered one cycle after rd_en.
// Backpressure: none; both ports accept an access every cycle.
module audio_delay_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              core_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // No reset and a registered read so the array maps onto block RAM.
    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_echo_stage.sv
// Rate-ticked feedback echo: mix, dry, delayed tap and 4-point moving average.
// Latency: outputs and sample_valid appear 4 cycles after the sample tick.
// Backpressure: none; the consumer must take each sample_valid pulse.
module audio_echo_stage
    import audio_fx_pkg::*;
#(
    parameter int DIV       = 1042,
    parameter int ADDR_W    = 10,
    parameter int MIX_SHIFT = 1,
    parameter int FB_SHIFT  = 2
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic        [ADDR_W-1:0]   delay_sel,
    input  logic                       clear,
    output logic signed [SAMPLE_W-1:0] final_audio,
    output logic signed [SAMPLE_W-1:0] final_audio_2,
    output logic signed [SAMPLE_W-1:0] final_audio_3,
    output logic signed [SAMPLE_W-1:0] final_audio_4,
    output logic                       sample_valid
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(DEPTH);

    state_t state, state_nxt;

    logic [15:0]         tick_cnt;
    logic                tick;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     fill_cnt;
    logic [ADDR_W-1:0]   dly_r;
    sample_t             dry_r;
    sample_t             tap_r;
    sample_t             hist_0, hist_1, hist_2;

    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] ram_rd_dat;
    logic                tap_force;
    logic                wr_en;
    sample_t             mix_tap, fb_tap;
    sum17_t              mix_sum, fb_sum;
    logic signed [SAMPLE_W+1:0] avg_sum;
    sample_t             wr_dat;

    assign tick = (tick_cnt == 16'(DIV - 1));

    // Pointer difference wraps naturally in ADDR_W bits.
    assign rd_addr   = wr_ptr - dly_r;
    assign tap_force = (dly_r == '0) || (fill_cnt < {1'b0, dly_r});

    assign mix_tap = tap_r >>> MIX_SHIFT;
    assign fb_tap  = tap_r >>> FB_SHIFT;
    assign mix_sum = {dry_r[SAMPLE_W-1], dry_r} + {mix_tap[SAMPLE_W-1], mix_tap};
    assign fb_sum  = {dry_r[SAMPLE_W-1], dry_r} + {fb_tap[SAMPLE_W-1], fb_tap};
    assign avg_sum = {{2{dry_r[SAMPLE_W-1]}},  dry_r}
                   + {{2{hist_0[SAMPLE_W-1]}}, hist_0}
                   + {{2{hist_1[SAMPLE_W-1]}}, hist_1}
                   + {{2{hist_2[SAMPLE_W-1]}}, hist_2};
    assign wr_dat  = sat16(fb_sum);

    // A clear landing on the write cycle must not disturb memory either.
    assign wr_en = (state == WR) && !clear;

    audio_delay_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .core_clk (clk_clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr),
        .wr_dat   (wr_dat),
        .rd_en    (state == RD),
        .rd_addr  (rd_addr),
        .rd_dat   (ram_rd_dat)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = RD;
            RD:      state_nxt = WAIT;
            WAIT:    state_nxt = CALC;
            CALC:    state_nxt = WR;
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tick_cnt      <= '0;
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            dly_r         <= '0;
            dry_r         <= '0;
            tap_r         <= '0;
            hist_0        <= '0;
            hist_1        <= '0;
            hist_2        <= '0;
            final_audio   <= '0;
            final_audio_2 <= '0;
            final_audio_3 <= '0;
            final_audio_4 <= '0;
            sample_valid  <= 1'b0;
        end else if (clear) begin
            tick_cnt      <= '0;
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            tap_r         <= '0;
            hist_0        <= '0;
            hist_1        <= '0;
            hist_2        <= '0;
            final_audio   <= '0;
            final_audio_2 <= '0;
            final_audio_3 <= '0;
            final_audio_4 <= '0;
            sample_valid  <= 1'b0;
        end else begin
            tick_cnt     <= tick ? '0 : tick_cnt + 16'd1;
            sample_valid <= 1'b0;

            if (state == IDLE && tick) begin
                dry_r <= sample_in;
                dly_r <= delay_sel;
            end

            // Memory behind the fill level is stale from before reset/clear.
            if (state == WAIT) begin
                tap_r <= tap_force ? '0 : $signed(ram_rd_dat);
            end

            if (state == CALC) begin
                final_audio   <= sat16(mix_sum);
                final_audio_2 <= dry_r;
                final_audio_3 <= tap_r;
                final_audio_4 <= avg_sum[SAMPLE_W+1:2];
                sample_valid  <= 1'b1;
                hist_0        <= dry_r;
                hist_1        <= hist_0;
                hist_2        <= hist_1;
            end

            if (state == WR) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill_cnt != FILL_MAX) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_echo_stage.sv
// Scoreboard bench for audio_echo_stage with DIV=8: directed vectors push
// expected results, a negedge monitor pops and compares on each sample_valid.
module tb_audio_echo_stage;

    localparam int DIV    = 8;
    localparam int RAMP_N = 2100;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b1;
    logic               clear     = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic        [9:0]  delay_sel = '0;
    logic signed [15:0] fa, f2, f3, f4;
    logic               sv;

    typedef struct {
        int fa;
        int f2;
        int f3;
        int f4;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ramp_w   [RAMP_N];
    int   ramp_tap [RAMP_N];

    always #5 clk = ~clk;

    audio_echo_stage #(
        .DIV       (DIV),
        .ADDR_W    (10),
        .MIX_SHIFT (1),
        .FB_SHIFT  (2)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sample_in     (sample_in),
        .delay_sel     (delay_sel),
        .clear         (clear),
        .final_audio   (fa),
        .final_audio_2 (f2),
        .final_audio_3 (f3),
        .final_audio_4 (f4),
        .sample_valid  (sv)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_final_audio"},   fa, 0);
        check({tag, "_final_audio_2"}, f2, 0);
        check({tag, "_final_audio_3"}, f3, 0);
        check({tag, "_final_audio_4"}, f4, 0);
        check({tag, "_sample_valid"},  int'(sv), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && sv) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("final_audio",   fa, mon_e.fa);
                check("final_audio_2", f2, mon_e.f2);
                check("final_audio_3", f3, mon_e.f3);
                check("final_audio_4", f4, mon_e.f4);
            end
        end
    end

    task automatic push_exp(input int efa, input int ef2, input int ef3, input int ef4);
        exp_t e;
        e = '{efa, ef2, ef3, ef4};
        sb.push_back(e);
    endtask

    task automatic wait_pulse(input string name);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (sv) return;
        end
        check({name, "_timeout"}, 0, 1);
        sb.delete();
    endtask

    task automatic issue(input logic signed [15:0] s, input logic [9:0] d,
                         input int efa, input int ef2, input int ef3, input int ef4);
        sample_in = s;
        delay_sel = d;
        push_exp(efa, ef2, ef3, ef4);
        wait_pulse("pulse");
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero("after_clear");
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;
        int tap, sum;

        // Ramp reference: delay 1023 returns the value written 1023 ticks earlier.
        for (int n = 0; n < RAMP_N; n++) begin
            ramp_tap[n] = (n < 1023) ? 0 : ramp_w[n-1023];
            ramp_w[n]   = n + (ramp_tap[n] >>> 2);
        end

        // Power-on reset.
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Bypass.
        sample_in = 16'sd1000;
        delay_sel = 10'd0;
        rst_n = 1'b1;
        issue(16'sd1000, 10'd0, 1000, 1000, 0, 250);
        issue(16'sd1000, 10'd0, 1000, 1000, 0, 500);
        issue(16'sd1000, 10'd0, 1000, 1000, 0, 750);
        issue(16'sd1000, 10'd0, 1000, 1000, 0, 1000);

        // Mid-run reset; the first pulse lands in the 12th cycle counting the release cycle as 1.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrun_reset");
        sample_in = 16'sd16000;
        delay_sel = 10'd3;
        push_exp(16000, 16000, 0, 4000);
        rst_n = 1'b1;
        cyc = 1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (sv) break;
        end
        check("first_pulse_cycle", cyc, DIV + 4);

        // Echo with feedback at delay 3.
        issue(16'sd0, 10'd3, 0,    0, 0,     4000);
        issue(16'sd0, 10'd3, 0,    0, 0,     4000);
        issue(16'sd0, 10'd3, 8000, 0, 16000, 4000);
        issue(16'sd0, 10'd3, 0,    0, 0,     0);
        issue(16'sd0, 10'd3, 0,    0, 0,     0);
        issue(16'sd0, 10'd3, 2000, 0, 4000,  0);
        issue(16'sd0, 10'd3, 0,    0, 0,     0);

        // Positive saturation, including a saturated feedback write.
        do_clear();
        issue(16'sd30000, 10'd1, 30000, 30000, 0,     7500);
        issue(16'sd30000, 10'd1, 32767, 30000, 30000, 15000);
        issue(16'sd30000, 10'd1, 32767, 30000, 32767, 22500);

        // Negative saturation and average rounding toward -inf.
        do_clear();
        issue(-16'sd30000, 10'd1, -30000, -30000, 0,      -7500);
        issue(-16'sd30000, 10'd1, -32768, -30000, -30000, -15000);
        issue(-16'sd30001, 10'd1, -32768, -30001, -32768, -22501);

        // Clear during WAIT: the pass started 4 cycles after this pulse is dropped.
        sample_in = 16'sd700;
        delay_sel = 10'd2;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero("clear_mid_pass");
        sample_in = 16'sd500;
        push_exp(500, 500, 0, 125);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (sv) pulses++;
        end
        check("pulses_after_clear", pulses, 0);
        wait_pulse("post_clear");
        issue(16'sd600, 10'd2, 600, 600, 0,   275);
        issue(16'sd700, 10'd2, 950, 700, 500, 450);

        // Ramp at full delay across two write-pointer wraps.
        do_clear();
        for (int n = 0; n < RAMP_N; n++) begin
            tap = ramp_tap[n];
            sum = n;
            if (n >= 1) sum += n - 1;
            if (n >= 2) sum += n - 2;
            if (n >= 3) sum += n - 3;
            issue(16'(n), 10'd1023, n + (tap >>> 1), n, tap, sum >>> 2);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
